// File: rtl/gate_vector_checker.sv
// Exhaustive stimulus generator and truth-table checker for a small combinational gate.
// Drives every input vector in ascending order, samples after a settle window, tallies mismatches.
module gate_vector_checker #(
   parameter int                  N_IN   = 2,
   parameter int                  SETTLE = 1,
   parameter logic [2**N_IN-1:0]  EXPECT = 4'b0001
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   output logic [N_IN-1:0] stim,
   input  logic            dut_y,
   output logic            busy,
   output logic            done,
   output logic            pass,
   output logic [N_IN:0]   err_count,
   output logic            fail_valid,
   output logic [N_IN-1:0] first_fail
);

   typedef enum logic [1:0] {IDLE, DRIVE, DONE} state_t;

   localparam logic [3:0]      SETTLE_C = 4'(SETTLE);
   localparam logic [N_IN-1:0] LAST_IDX = '1;

   state_t          state, state_next;
   logic [N_IN-1:0] idx;
   logic [3:0]      cnt;
   logic            sample;
   logic            mismatch;
   logic            last_vec;

   assign sample   = (state == DRIVE) && (cnt == SETTLE_C);
   assign mismatch = sample && (dut_y != EXPECT[idx]);
   assign last_vec = (idx == LAST_IDX);

   assign stim = (state == DRIVE) ? idx : '0;
   assign busy = (state == DRIVE);
   assign done = (state == DONE);

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_next;
   end

   // NOTE: next state gets a default first so no path through the case can infer a latch.
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (start) state_next = DRIVE;
         DRIVE:   if (sample && last_vec) state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx        <= '0;
         cnt        <= '0;
         pass       <= 1'b0;
         err_count  <= '0;
         fail_valid <= 1'b0;
         first_fail <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  idx        <= '0;
                  cnt        <= '0;
                  pass       <= 1'b0;
                  err_count  <= '0;
                  fail_valid <= 1'b0;
                  first_fail <= '0;
               end
            end
            DRIVE: begin
               if (sample) begin
                  cnt <= '0;
                  if (!last_vec) idx <= idx + 1'b1;
                  if (mismatch) begin
                     err_count <= err_count + 1'b1;
                     if (!fail_valid) begin
                        first_fail <= idx;
                        fail_valid <= 1'b1;
                     end
                  end
                  // The final compare decides pass, so fold in its own result.
                  if (last_vec) pass <= (err_count == '0) && !mismatch;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
